// File: rtl/vram_pkg.sv
// Shared encodings for the VRAM pattern writer: fill modes,
// FSM state constants and the LFSR feedback taps.
package vram_pkg;

    localparam logic [1:0] MODE_CONST = 2'd0;
    localparam logic [1:0] MODE_INCR  = 2'd1;
    localparam logic [1:0] MODE_LFSR  = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_WAIT    = 3'd1;
    localparam state_t S_WR_CHAR = 3'd2;
    localparam state_t S_WR_ATTR = 3'd3;
    localparam state_t S_DONE    = 3'd4;

    // Taps 15,13,12,10 feed bit 0 on each shift.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_seed_fix(
        input logic [15:0] s
    );
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/vram_pattern_writer_if.sv
// VRAM A-port write bus between the pattern writer
// (master) and the video block's VRAM (slave).
interface vram_pattern_writer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) ();
    logic              vram_cea_o;
    logic [ADDR_W-1:0] vram_ada_o;
    logic [DATA_W-1:0] vram_din_o;

    modport master (
        output vram_cea_o,
        output vram_ada_o,
        output vram_din_o
    );

    modport slave (
        input vram_cea_o,
        input vram_ada_o,
        input vram_din_o
    );
endinterface

// File: rtl/vram_pattern_writer_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load and step
// enable; a zero seed is replaced by 1 to avoid lock-up.
module lfsr16
    import vram_pkg::*;
#(
    parameter logic [15:0] SEED = 16'h0001
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        load_i,
    input  logic        adv_i,
    output logic [15:0] q_o
);

    localparam logic [15:0] INIT = lfsr_seed_fix(SEED);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_o <= INIT;
        end else if (load_i) begin
            q_o <= INIT;
        end else if (adv_i) begin
            q_o <= {q_o[14:0], ^(q_o & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/vram_pattern_writer.sv
// Paced text-mode VRAM fill engine (const/incr/LFSR/checker).
// Define ATTR_WRITE_EN to also write attr_i after every char.
module vram_pattern_writer
    import vram_pkg::*;
#(
    parameter int          COLS      = 60,
    parameter int          ROWS      = 34,
    parameter int          ADDR_W    = 12,
    parameter int          DATA_W    = 8,
    parameter int          PACE_W    = 10,
    parameter logic [15:0] LFSR_SEED = 16'h0001
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] fill_i,
    input  logic [DATA_W-1:0] attr_i,
    input  logic [PACE_W-1:0] pace_i,
    input  logic [ADDR_W-1:0] base_i,
    output logic              busy_o,
    output logic              done_o,
    vram_pattern_writer_if.master vram
);

    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);
    localparam int KW = $clog2(COLS * ROWS + 1);

    state_t            state;
    state_t            nxt;
    logic [PACE_W-1:0] pace_cnt;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [PACE_W-1:0] pace_q;
    logic [ADDR_W-1:0] base_q;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [KW-1:0]     k;
    logic [15:0]       lfsr_q;
    logic [DATA_W-1:0] pat;
    logic [ADDR_W-1:0] char_ada;
    logic [ADDR_W-1:0] cur_ada;
    logic [DATA_W-1:0] cur_din;
    logic [ADDR_W-1:0] ada_q;
    logic [DATA_W-1:0] din_q;
    logic              start_acc;
    logic              wr_char;
    logic              wr_attr;
    logic              wr;
    logic              cell_end;
    logic              last_cell;
    logic              unused_bits;

    assign start_acc = (state == S_IDLE) && start_i && !abort_i;
    assign wr_char   = (state == S_WR_CHAR) && !abort_i;
    assign last_cell = (col == CW'(COLS - 1))
                    && (row == RW'(ROWS - 1));
    assign char_ada  = base_q + ADDR_W'({k, 1'b0});

`ifdef ATTR_WRITE_EN
    logic [DATA_W-1:0] attr_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            attr_q <= '0;
        end else if (start_acc) begin
            attr_q <= attr_i;
        end
    end

    assign wr_attr     = (state == S_WR_ATTR) && !abort_i;
    assign cell_end    = wr_attr;
    assign cur_ada     = wr_attr ? char_ada + ADDR_W'(1)
                                 : char_ada;
    assign cur_din     = wr_attr ? attr_q : pat;
    assign unused_bits = ^lfsr_q[15:8];
`else
    assign wr_attr     = 1'b0;
    assign cell_end    = wr_char;
    assign cur_ada     = char_ada;
    assign cur_din     = pat;
    assign unused_bits = ^{lfsr_q[15:8], attr_i};
`endif

    assign wr = wr_char | wr_attr;

    always_comb begin
        pat = fill_q;
        unique case (mode_q)
            MODE_CONST: pat = fill_q;
            MODE_INCR:  pat = fill_q + DATA_W'(k);
            MODE_LFSR:  pat = DATA_W'(lfsr_q[7:0]);
            MODE_CHECK: pat = (col[0] ^ row[0]) ? ~fill_q
                                                : fill_q;
            default:    pat = fill_q;
        endcase
    end

    always_comb begin
        nxt = S_WAIT;
        if (last_cell) begin
            nxt = S_DONE;
        end else if (pace_q == '0) begin
            nxt = S_WR_CHAR;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= S_IDLE;
            pace_cnt <= '0;
        end else if (abort_i) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        pace_cnt <= pace_i;
                        state    <= (pace_i == '0) ? S_WR_CHAR
                                                   : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pace_cnt == PACE_W'(1)) begin
                        state <= S_WR_CHAR;
                    end else begin
                        pace_cnt <= pace_cnt - PACE_W'(1);
                    end
                end
                S_WR_CHAR: begin
`ifdef ATTR_WRITE_EN
                    state <= S_WR_ATTR;
`else
                    state    <= nxt;
                    pace_cnt <= pace_q;
`endif
                end
                S_WR_ATTR: begin
                    state    <= nxt;
                    pace_cnt <= pace_q;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q <= '0;
            fill_q <= '0;
            pace_q <= '0;
            base_q <= '0;
        end else if (start_acc) begin
            mode_q <= mode_i;
            fill_q <= fill_i;
            pace_q <= pace_i;
            base_q <= base_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col <= '0;
            row <= '0;
            k   <= '0;
        end else if (start_acc) begin
            col <= '0;
            row <= '0;
            k   <= '0;
        end else if (cell_end) begin
            k <= k + KW'(1);
            if (col == CW'(COLS - 1)) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Bus holds the last written address/data between strobes.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ada_q <= '0;
            din_q <= '0;
        end else if (wr) begin
            ada_q <= cur_ada;
            din_q <= cur_din;
        end
    end

    lfsr16 #(
        .SEED   (LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .load_i (start_acc),
        .adv_i  (wr_char),
        .q_o    (lfsr_q)
    );

    assign vram.vram_cea_o = wr;
    assign vram.vram_ada_o = wr ? cur_ada : ada_q;
    assign vram.vram_din_o = wr ? cur_din : din_q;

    assign busy_o = (state == S_WAIT)
                 || (state == S_WR_CHAR)
                 || (state == S_WR_ATTR);
    assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_vram_pattern_writer.sv
// Bench for vram_pattern_writer: write-schedule model plus
// per-cycle bus/handshake compare and literal spot checks.
module tb_vram_pattern_writer;

    localparam int COLS = 4;
    localparam int ROWS = 2;
`ifdef ATTR_WRITE_EN
    localparam int AX = 1;
`else
    localparam int AX = 0;
`endif

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  mode  = '0;
    logic [7:0]  fill  = '0;
    logic [7:0]  attr  = '0;
    logic [9:0]  pace  = '0;
    logic [11:0] base  = '0;
    logic        busy;
    logic        done;

    vram_pattern_writer_if #(.ADDR_W(12), .DATA_W(8)) vif ();

    vram_pattern_writer #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .ADDR_W    (12),
        .DATA_W    (8),
        .PACE_W    (10),
        .LFSR_SEED (16'h0001)
    ) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .start_i (start),
        .abort_i (abort),
        .mode_i  (mode),
        .fill_i  (fill),
        .attr_i  (attr),
        .pace_i  (pace),
        .base_i  (base),
        .busy_o  (busy),
        .done_o  (done),
        .vram    (vif.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [11:0] a;
        logic [7:0]  d;
        bit          at;
    } wr_t;

    wr_t         exq[$];
    wr_t         log_q[$];
    int          busy_from = 1;
    int          busy_to   = 0;
    int          done_at   = -1;
    int          end_cyc   = 0;
    logic [11:0] last_a    = '0;
    logic [7:0]  last_d    = '0;
    int          total     = 0;
    int          bad       = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Expected write schedule from the fill rules.
    function automatic void plan(input int n,
                                 input logic [1:0] m,
                                 input logic [7:0] f,
                                 input logic [7:0] at,
                                 input int p,
                                 input logic [11:0] b);
        logic [15:0] l;
        logic [7:0]  d;
        logic [11:0] a;
        int t, step, lastw, c, r;
        l = 16'h0001;
        t = n + 1 + p;
        step = p + 1 + AX;
        lastw = t;
        for (int k = 0; k < COLS * ROWS; k++) begin
            c = k % COLS;
            r = k / COLS;
            case (m)
                2'd0: d = f;
                2'd1: d = f + 8'(k);
                2'd2: d = l[7:0];
                default: d = (((c ^ r) & 1) != 0) ? ~f : f;
            endcase
            a = b + 12'(2 * k);
            exq.push_back('{t, a, d, 1'b0});
            lastw = t;
            if (AX != 0) begin
                exq.push_back('{t + 1, a + 12'd1, at, 1'b1});
                lastw = t + 1;
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            t += step;
        end
        busy_from = n + 1;
        busy_to   = lastw;
        done_at   = lastw + 1;
        end_cyc   = lastw + 2;
        log_q.delete();
    endfunction

    function automatic void model_abort(input int ac);
        while (exq.size() > 0 && exq[$].cyc >= ac)
            void'(exq.pop_back());
        busy_to = ac;
        done_at = -1;
        end_cyc = ac + 2;
    endfunction

    function automatic void model_reset();
        exq.delete();
        busy_from = 1;
        busy_to   = 0;
        done_at   = -1;
        last_a    = '0;
        last_d    = '0;
    endfunction

    always @(negedge clk) begin : cmp
        wr_t e;
        bit  want;
        want = (exq.size() > 0) && (exq[0].cyc == cyc);
        chk("cea", 32'(vif.vram_cea_o), 32'(want));
        if (want) begin
            e = exq.pop_front();
            chk("ada", 32'(vif.vram_ada_o), 32'(e.a));
            chk("din", 32'(vif.vram_din_o), 32'(e.d));
            last_a = e.a;
            last_d = e.d;
            if (!e.at && vif.vram_cea_o)
                log_q.push_back('{cyc, vif.vram_ada_o,
                                  vif.vram_din_o, 1'b0});
        end else begin
            chk("ada_hold", 32'(vif.vram_ada_o), 32'(last_a));
            chk("din_hold", 32'(vif.vram_din_o), 32'(last_d));
        end
        chk("busy", 32'(busy),
            32'(cyc >= busy_from && cyc <= busy_to));
        chk("done", 32'(done), 32'(cyc == done_at));
    end

    task automatic start_fill(input logic [1:0] m,
                              input logic [7:0] f,
                              input logic [7:0] at,
                              input int p,
                              input logic [11:0] b,
                              output int n);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        fill  = f;
        attr  = at;
        pace  = 10'(p);
        base  = b;
        n = cyc;
        plan(n, m, f, at, p, b);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 400; i++) begin
            if (cyc > end_cyc) begin
                chk("drain", 32'(exq.size()), 32'd0);
                return;
            end
            @(posedge clk); #1;
        end
        chk("timeout", 32'd1, 32'd0);
    endtask

    task automatic step(input int c);
        repeat (c) begin
            @(posedge clk); #1;
        end
    endtask

    int n;
    int t3;

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cea", 32'(vif.vram_cea_o), 32'd0);
        chk("rst_ada", 32'(vif.vram_ada_o), 32'd0);
        chk("rst_din", 32'(vif.vram_din_o), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        step(2);

        // const fill, back-to-back
        start_fill(2'd0, 8'h41, 8'h1F, 0, 12'h000, n);
        wait_end();
        chk("t1_cnt", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            chk("t1_addr", 32'(log_q[i].a), 32'(2 * i));
            chk("t1_data", 32'(log_q[i].d), 32'h41);
        end
        chk("t1_first", 32'(log_q[0].cyc - n), 32'd1);

        // LFSR, pace 3
        start_fill(2'd2, 8'h00, 8'h1F, 3, 12'h100, n);
        wait_end();
        chk("t2_cnt", 32'(log_q.size()), 32'd8);
        chk("t2_d0", 32'(log_q[0].d), 32'h01);
        chk("t2_d1", 32'(log_q[1].d), 32'h02);
        chk("t2_d3", 32'(log_q[3].d), 32'h08);
        chk("t2_d7", 32'(log_q[7].d), 32'h80);
        chk("t2_first", 32'(log_q[0].cyc - n), 32'd4);
        chk("t2_space", 32'(log_q[1].cyc - log_q[0].cyc),
            32'(4 + AX));

        // checker with an ignored start mid-fill
        start_fill(2'd3, 8'hAA, 8'h1F, 2, 12'h200, n);
        step(2);
        start = 1'b1;
        mode  = 2'd0;
        fill  = 8'h00;
        pace  = 10'd0;
        base  = 12'h000;
        step(1);
        start = 1'b0;
        wait_end();
        chk("t3_cnt", 32'(log_q.size()), 32'd8);
        chk("t3_r0c0", 32'(log_q[0].d), 32'hAA);
        chk("t3_r0c1", 32'(log_q[1].d), 32'h55);
        chk("t3_r0c3", 32'(log_q[3].d), 32'h55);
        chk("t3_r1c0", 32'(log_q[4].d), 32'h55);
        chk("t3_r1c1", 32'(log_q[5].d), 32'hAA);
        chk("t3_r1c3", 32'(log_q[7].d), 32'hAA);

        // address wrap, incrementing data
        start_fill(2'd1, 8'h00, 8'h1F, 0, 12'hFFE, n);
        wait_end();
        chk("t4_a0", 32'(log_q[0].a), 32'hFFE);
        chk("t4_a1", 32'(log_q[1].a), 32'h000);
        chk("t4_a2", 32'(log_q[2].a), 32'h002);
        chk("t4_d0", 32'(log_q[0].d), 32'h00);
        chk("t4_d1", 32'(log_q[1].d), 32'h01);
        chk("t4_d2", 32'(log_q[2].d), 32'h02);

        // abort on the third strobe
        start_fill(2'd0, 8'h33, 8'h1F, 1, 12'h040, n);
        t3 = exq[2].cyc;
        for (int i = 0; i < 50 && cyc < t3; i++) step(1);
        abort = 1'b1;
        model_abort(t3);
        step(1);
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        wait_end();
        chk("t5_cnt", 32'(log_q.size()), 32'(2 - AX));

        // restart after abort
        start_fill(2'd1, 8'h10, 8'h1F, 0, 12'h020, n);
        wait_end();
        chk("t6_d0", 32'(log_q[0].d), 32'h10);
        chk("t6_d7", 32'(log_q[7].d), 32'h17);
        chk("t6_a7", 32'(log_q[7].a), 32'h02E);

        // reset mid-fill
        start_fill(2'd0, 8'h77, 8'h1F, 2, 12'h300, n);
        step(4);
        rstn = 1'b0;
        model_reset();
        step(2);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_ada", 32'(vif.vram_ada_o), 32'd0);
        rstn = 1'b1;
        step(1);

        start_fill(2'd0, 8'h5C, 8'h1F, 0, 12'h010, n);
        wait_end();
        chk("t8_cnt", 32'(log_q.size()), 32'd8);
        chk("t8_d0", 32'(log_q[0].d), 32'h5C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
